// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared PC width, reset address and fetch-buffer entry layout
package ifetch_unit_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush priority; head reads as zero when empty
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic          do_pop, do_push;
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk)
    if (rst || flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= do_pop ? rd + 1'b1 : rd;
      wr    <= do_push ? wr + 1'b1 : wr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC owner issuing in-order IROM fetches, buffering {pc, inst} for decode
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            irom_req_valid,
  output logic [PC_W-1:0] irom_req_addr,
  input  logic            irom_req_ready,
  input  logic            irom_resp_valid,
  input  logic [31:0]     irom_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic [PC_W-1:0] if_pc4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW + 1)'(FIFO_DEPTH);
  logic [PC_W-1:0] fetch_pc, tag_pc;
  logic [CW-1:0]   outstanding, stale, fifo_count, tag_count;
  logic            fifo_empty, fifo_full, tag_empty, tag_full;
  logic            req_fire, push, pop;
  fetch_entry_t    head;
  // outstanding includes stale requests, so every live response is guaranteed a slot
  assign irom_req_valid = !cpu_rst && !redirect_valid && ({1'b0, fifo_count} + {1'b0, outstanding} < CAP);
  assign req_fire       = irom_req_valid && irom_req_ready;
  assign push           = irom_resp_valid && stale == '0 && !redirect_valid;
  assign pop            = if_valid && if_ready;
  assign irom_req_addr  = fetch_pc;
  assign if_valid       = !fifo_empty;
  assign if_pc          = head.pc;
  assign if_inst        = head.inst;
  assign if_pc4         = head.pc + 32'd4;
  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) data_q (
    .clk(cpu_clk), .rst(cpu_rst), .flush(redirect_valid), .push(push),
    .din({tag_pc, irom_resp_data}), .pop(pop), .dout(head),
    .count(fifo_count), .empty(fifo_empty), .full(fifo_full)
  );
  // tags for every in-flight request, stale or not; popped by each response
  fetch_fifo #(.W(PC_W), .DEPTH(FIFO_DEPTH)) tag_q (
    .clk(cpu_clk), .rst(cpu_rst), .flush(1'b0), .push(req_fire),
    .din(fetch_pc), .pop(irom_resp_valid), .dout(tag_pc),
    .count(tag_count), .empty(tag_empty), .full(tag_full)
  );
  always_ff @(posedge cpu_clk)
    if (cpu_rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      fetch_pc    <= redirect_valid ? redirect_pc & ~32'd3 : req_fire ? fetch_pc + 32'd4 : fetch_pc;
      outstanding <= outstanding + CW'(req_fire) - CW'(irom_resp_valid);
      stale       <= redirect_valid ? outstanding - CW'(irom_resp_valid) :
                     (irom_resp_valid && stale != '0) ? stale - 1'b1 : stale;
    end
  always_ff @(posedge cpu_clk)
    if (!cpu_rst) begin
      assert (!(irom_resp_valid && outstanding == '0));
      assert (tag_count == outstanding && !(req_fire && tag_full) && !(irom_resp_valid && tag_empty));
      assert (!(push && fifo_full && !pop));
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized traffic checked against an epoch-tagged queue model of fetch
module tb_ifetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  logic        cpu_clk = 1'b0, cpu_rst = 1'b1;
  logic        redirect_valid = 1'b0, irom_req_ready = 1'b0, irom_resp_valid = 1'b0, if_ready = 1'b0;
  logic [31:0] redirect_pc = '0, irom_resp_data = '0;
  logic        irom_req_valid, if_valid;
  logic [31:0] irom_req_addr, if_pc, if_inst, if_pc4;

  ifetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .irom_req_valid(irom_req_valid), .irom_req_addr(irom_req_addr), .irom_req_ready(irom_req_ready),
    .irom_resp_valid(irom_resp_valid), .irom_resp_data(irom_resp_data), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst), .if_pc4(if_pc4)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  req_t        pend[$];
  ent_t        q[$];
  logic [31:0] iss[$], took[$], took4[$];
  logic [31:0] mfetch = RPC;
  int          epoch, cyc, last_due, n_cmp, n_bad;
  int          lat = 1, rdy_pct = 100, irdy_pct = 100, redir_pct = 0;
  bit          force_redir, rst_req = 1'b1, inited;
  logic [31:0] force_tgt;
  logic        obs_req_valid, obs_if_valid;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] l[$], input int i);
    return l.size() > i ? l[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit   exp_req, fire, resp, live;
    req_t r;
    int   due;
    @(negedge cpu_clk);
    cpu_rst         = rst_req;
    redirect_valid  = !rst_req && (force_redir || $urandom_range(99) < redir_pct);
    redirect_pc     = force_redir ? force_tgt : $urandom;
    irom_req_ready  = $urandom_range(99) < irdy_pct;
    if_ready        = $urandom_range(99) < rdy_pct;
    irom_resp_valid = !rst_req && pend.size() > 0 && pend[0].due <= cyc;
    irom_resp_data  = irom_resp_valid ? rom(pend[0].addr) : $urandom;
    #1;
    exp_req = !rst_req && !redirect_valid && (q.size() + pend.size() < DEPTH);
    obs_req_valid = irom_req_valid;
    obs_if_valid  = if_valid;
    check("req_valid", {31'b0, irom_req_valid}, {31'b0, exp_req});
    if (inited) begin
      check("req_addr", irom_req_addr, mfetch);
      check("if_valid", {31'b0, if_valid}, {31'b0, q.size() > 0});
      check("if_pc", if_pc, q.size() > 0 ? q[0].pc : 32'h0);
      check("if_inst", if_inst, q.size() > 0 ? q[0].inst : 32'h0);
      check("if_pc4", if_pc4, (q.size() > 0 ? q[0].pc : 32'h0) + 32'd4);
    end
    fire = exp_req && irom_req_ready;
    resp = irom_resp_valid;
    if (rst_req) begin
      q.delete(); pend.delete();
      mfetch = RPC; last_due = 0; inited = 1'b1;
    end else begin
      live = 1'b0;
      if (resp) begin
        r = pend.pop_front();
        live = r.epoch == epoch;
      end
      if (redirect_valid) begin
        q.delete();
        epoch++;
        mfetch = redirect_pc & ~32'd3;
      end else begin
        if (if_ready && q.size() > 0) begin
          took.push_back(if_pc);
          took4.push_back(if_pc4);
          void'(q.pop_front());
        end
        if (live) q.push_back('{r.addr, rom(r.addr)});
        if (fire) begin
          iss.push_back(irom_req_addr);
          due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
          last_due = due;
          pend.push_back('{mfetch, epoch, due});
          mfetch = mfetch + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    iss.delete(); took.delete(); took4.delete();
  endtask

  task automatic redirect_to(input logic [31:0] t);
    force_redir = 1'b1; force_tgt = t;
    step();
    force_redir = 1'b0;
    iss.delete(); took.delete(); took4.delete();
  endtask

  initial begin
    // T1: reset then streaming with 1-cycle latency
    do_reset();
    repeat (10) step();
    check("t1_req0", at(iss, 0), 32'h0);
    check("t1_req1", at(iss, 1), 32'h4);
    check("t1_req2", at(iss, 2), 32'h8);
    check("t1_pc0", at(took, 0), 32'h0);
    check("t1_pc4", at(took4, 0), 32'h4);
    // T2: decode stalled, credit caps requests at DEPTH
    do_reset();
    rdy_pct = 0;
    repeat (10) step();
    check("t2_nreq", iss.size(), DEPTH);
    check("t2_req_off", {31'b0, obs_req_valid}, 32'h0);
    rdy_pct = 100;
    repeat (3) step();
    check("t2_pc0", at(took, 0), 32'h0);
    check("t2_pc1", at(took, 1), 32'h4);
    // T3: redirect with two requests in flight, both dropped
    do_reset();
    lat = 3;
    for (int i = 0; i < 20 && pend.size() != 2; i++) step();
    check("t3_inflight", pend.size(), 2);
    redirect_to(32'h100);
    repeat (14) step();
    check("t3_pc0", at(took, 0), 32'h100);
    check("t3_pc1", at(took, 1), 32'h104);
    // T4: redirect, response and pop all in the same cycle
    do_reset();
    lat = 1;
    for (int i = 0; i < 30 && !(q.size() > 0 && pend.size() > 0 && pend[0].due <= cyc); i++) step();
    check("t4_setup", {31'b0, q.size() > 0 && pend.size() > 0 && pend[0].due <= cyc}, 32'h1);
    redirect_to(32'h100);
    check("t4_no_req", {31'b0, obs_req_valid}, 32'h0);
    step();
    check("t4_empty", {31'b0, obs_if_valid}, 32'h0);
    repeat (6) step();
    check("t4_req0", at(iss, 0), 32'h100);
    check("t4_pc0", at(took, 0), 32'h100);
    // T5: unaligned target near the top of the address space
    redirect_to(32'hFFFF_FFFE);
    repeat (10) step();
    check("t5_req0", at(iss, 0), 32'hFFFF_FFFC);
    check("t5_req1", at(iss, 1), 32'h0);
    check("t5_pc0", at(took, 0), 32'hFFFF_FFFC);
    check("t5_wrap4", at(took4, 0), 32'h0);
    // T6: reset while buffer and IROM hold data
    rdy_pct = 0; lat = 2;
    for (int i = 0; i < 30 && !(q.size() > 0 && q.size() + pend.size() == DEPTH); i++) step();
    check("t6_setup", q.size() + pend.size(), DEPTH);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    iss.delete(); took.delete(); took4.delete();
    step();
    check("t6_flushed", {31'b0, obs_if_valid}, 32'h0);
    rdy_pct = 100;
    repeat (6) step();
    check("t6_restart", at(iss, 0), RPC);
    check("t6_pc0", at(took, 0), RPC);
    // random traffic with redirects, stalls, latency changes and occasional reset
    rdy_pct = 60; irdy_pct = 70; redir_pct = 5;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) lat = $urandom_range(1, 4);
      rst_req = $urandom_range(299) == 0;
      step();
    end
    rst_req = 1'b0; redir_pct = 0; rdy_pct = 100; irdy_pct = 100;
    repeat (20) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
